microtile_pwm_bank: RTL and testbench

Parametrised multi-channel PWM microtile with registered outputs. It is the clocked successor to the combinational Wokwi microtiles and uses the same `ui_in`/`uo_out` pin budget. Duty values are written nibble-wise through `ui_in` with a strobe, held in shadow registers, and applied glitch-free at the period wrap. It sits directly behind the tile pins with no other logic.

---
 rtl/microtile_pwm_pkg.sv | 32 +++
 rtl/microtile_pwm_channel.sv | 60 ++++++
 rtl/microtile_pwm_bank.sv | 100 ++++++++++
 tb/tb_microtile_pwm_bank.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microtile_pwm_pkg.sv
// microtile_pwm_pkg: shared constants and the ui_in control-word layout for the
// microtile PWM bank.
package microtile_pwm_pkg;

  localparam int MAX_CHANNELS = 8;
  localparam int MAX_WIDTH    = 8;

  localparam int UI_STB_BIT = 7;
  localparam int UI_SEL_LSB = 4;
  localparam int UI_SEL_MSB = 6;
  localparam int UI_NIB_MSB = 3;

  localparam int SEL_W = UI_SEL_MSB - UI_SEL_LSB + 1;
  localparam int NIB_W = UI_NIB_MSB + 1;

  // Decoded view of the 8-bit control word.
  typedef struct packed {
    logic             stb;
    logic [SEL_W-1:0] sel;
    logic [NIB_W-1:0] nib;
  } ui_word_t;

  // Split a raw control word into its fields.
  function automatic ui_word_t decode_ui(input logic [7:0] raw);
    ui_word_t w;
    w.stb = raw[UI_STB_BIT];
    w.sel = raw[UI_SEL_MSB:UI_SEL_LSB];
    w.nib = raw[UI_NIB_MSB:0];
    return w;
  endfunction

endpackage

// File: rtl/microtile_pwm_channel.sv
// microtile_pwm_channel: one PWM lane. Holds the shadow duty written through
// ui_in, the active duty used by the comparator, and the registered output.
// The active duty only changes on the wrap edge, so a period is never cut short.
module microtile_pwm_channel
  import microtile_pwm_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             wr_en,
  input  logic [NIB_W-1:0] nib,
  input  logic             wrap,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm
);

  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] shadow_next;

  // Narrow duties load directly; wide duties shift in one nibble per write,
  // so the MS nibble goes first and the LS nibble last.
  generate
    if (WIDTH > NIB_W) begin : g_shift
      assign shadow_next = {shadow[WIDTH-NIB_W-1:0], nib};
    end else begin : g_direct
      assign shadow_next = nib[WIDTH-1:0];
    end
  endgenerate

  // Shadow duty register, updated by strobe writes addressed to this lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (wr_en) begin
      shadow <= shadow_next;
    end
  end

  // Active duty takes the pre-write shadow on the wrap edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= '0;
    end else if (wrap) begin
      active <= shadow;
    end
  end

  // Registered comparator; full-scale duty still leaves one low cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm <= 1'b0;
    end else if (ena) begin
      pwm <= (cnt < active);
    end
  end

endmodule

// File: rtl/microtile_pwm_bank.sv
// microtile_pwm_bank: multi-channel PWM tile behind the ui_in/uo_out pins.
// Holds the shared period counter, strobe edge detect, optional input
// synchroniser and output packing; each lane lives in microtile_pwm_channel.
// Build option: define MICROTILE_PWM_SYNC_EN to pass ui_in through a two-flop
// synchroniser before decode (write lands two edges later).
module microtile_pwm_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  import microtile_pwm_pkg::*;

  // Out-of-range parameters are clamped to what the pin budget can carry.
  localparam int CH_N   = (CHANNELS > MAX_CHANNELS) ? MAX_CHANNELS : CHANNELS;
  localparam int DUTY_W = (WIDTH > MAX_WIDTH) ? MAX_WIDTH : WIDTH;

  logic [7:0]        ui_eff;
  ui_word_t          ui_w;
  logic              stb_q;
  logic              wr_fire;
  logic              wrap;
  logic [DUTY_W-1:0] cnt;
  logic [CH_N-1:0]   pwm;

`ifdef MICROTILE_PWM_SYNC_EN
  logic [7:0] ui_meta;
  logic [7:0] ui_sync;

  // Two-flop synchroniser on the whole word keeps data coherent with strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ui_meta <= '0;
      ui_sync <= '0;
    end else begin
      ui_meta <= ui_in;
      ui_sync <= ui_meta;
    end
  end

  assign ui_eff = ui_sync;
`else
  assign ui_eff = ui_in;
`endif

  assign ui_w    = decode_ui(ui_eff);
  assign wr_fire = ena && ui_w.stb && !stb_q;
  assign wrap    = ena && (cnt == {DUTY_W{1'b1}});

  // Previous strobe level; frozen with the rest of the tile when ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_q <= 1'b0;
    end else if (ena) begin
      stb_q <= ui_w.stb;
    end
  end

  // Free-running period counter, wraps naturally at 2^WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Lanes; a select at or above CH_N matches no lane and is dropped.
  generate
    for (genvar i = 0; i < CH_N; i++) begin : g_ch
      logic wr_en;
      assign wr_en = wr_fire && (ui_w.sel == SEL_W'(i));

      microtile_pwm_channel #(
        .WIDTH (DUTY_W)
      ) u_ch (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .wr_en (wr_en),
        .nib   (ui_w.nib),
        .wrap  (wrap),
        .cnt   (cnt),
        .pwm   (pwm[i])
      );
    end
  endgenerate

  // Pack lane outputs into the low pins; unused pins stay 0.
  always_comb begin
    uo_out = '0;
    uo_out[CH_N-1:0] = pwm;
  end

endmodule

// File: tb/tb_microtile_pwm_bank.sv
// Self-checking bench for microtile_pwm_bank: a 4x4 and an 8x8 instance share
// stimulus; a behavioural model pushes expected outputs to a scoreboard queue
// and window counts check duty cycles directly.
module tb_microtile_pwm_bank;

`ifdef MICROTILE_PWM_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_a;
  logic [7:0] uo_b;

  int n_checks = 0;
  int n_errors = 0;

  microtile_pwm_bank dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_a));

  microtile_pwm_bank #(.CHANNELS(8), .WIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_b));

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model state, index 0 = 4x4 instance, 1 = 8x8 instance.
  int         mw [2] = '{4, 8};
  int         mc [2] = '{4, 8};
  int         m_cnt [2];
  int         m_sh  [2][8];
  int         m_act [2][8];
  logic [7:0] m_pwm [2];
  logic       m_stb [2];
  logic [7:0] m_s1  [2];
  logic [7:0] m_s2  [2];

  typedef struct { logic [7:0] a; logic [7:0] b; } exp_t;
  exp_t exp_q[$];

  int hi_a [8];
  int hi_b [8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0;
      m_pwm[d] = '0;
      m_stb[d] = 1'b0;
      m_s1[d]  = '0;
      m_s2[d]  = '0;
      for (int i = 0; i < 8; i++) begin
        m_sh[d][i]  = 0;
        m_act[d][i] = 0;
      end
    end
  endtask

  task automatic model_step(input int d, input logic [7:0] ui, input logic en);
    logic [7:0] u;
    int per;
    int sel;
    per = 1 << mw[d];
`ifdef MICROTILE_PWM_SYNC_EN
    u = m_s2[d];
    m_s2[d] = m_s1[d];
    m_s1[d] = ui;
`else
    u = ui;
`endif
    if (!en) return;
    for (int i = 0; i < mc[d]; i++) m_pwm[d][i] = (m_cnt[d] < m_act[d][i]);
    if (m_cnt[d] == per - 1)
      for (int i = 0; i < mc[d]; i++) m_act[d][i] = m_sh[d][i];
    if (u[7] && !m_stb[d]) begin
      sel = int'(u[6:4]);
      if (sel < mc[d]) begin
        if (mw[d] <= 4) m_sh[d][sel] = int'(u[3:0]) % per;
        else            m_sh[d][sel] = (m_sh[d][sel] * 16 + int'(u[3:0])) % per;
      end
    end
    m_stb[d] = u[7];
    m_cnt[d] = (m_cnt[d] + 1) % per;
  endtask

  // One clock: drive at negedge, predict, then compare just after posedge.
  task automatic cycle(input logic [7:0] ui, input logic en);
    exp_t e;
    @(negedge clk);
    ui_in = ui;
    ena   = en;
    if (!rst_n) begin
      model_reset();
    end else begin
      model_step(0, ui, en);
      model_step(1, ui, en);
    end
    exp_q.push_back('{a: m_pwm[0], b: m_pwm[1]});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("uo_out_4x4", {24'd0, uo_a}, {24'd0, e.a});
    check_eq("uo_out_8x8", {24'd0, uo_b}, {24'd0, e.b});
    for (int i = 0; i < 8; i++) begin
      hi_a[i] += int'(uo_a[i]);
      hi_b[i] += int'(uo_b[i]);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(8'h00, 1'b1);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 8; i++) begin
      hi_a[i] = 0;
      hi_b[i] = 0;
    end
  endtask

  task automatic wr(input int sel, input int nib);
    logic [7:0] w;
    w = {1'b0, 3'(sel), 4'(nib)};
    cycle(w, 1'b1);
    cycle(w | 8'h80, 1'b1);
    cycle(w, 1'b1);
  endtask

  task automatic wait_cnt(input int d, input int target);
    for (int k = 0; k < 600 && m_cnt[d] != target; k++) cycle(8'h00, 1'b1);
    if (m_cnt[d] != target) begin
      n_errors++;
      $display("FAIL wait_cnt: counter target %0d not reached", target);
    end
  endtask

  initial begin
    model_reset();
    clear_counts();

    // Reset held, then 40 idle cycles: everything low.
    for (int k = 0; k < 5; k++) cycle(8'h00, 1'b1);
    rst_n = 1'b1;
    clear_counts();
    idle(40);
    check_eq("reset_idle_hi_a", hi_a[0] + hi_a[1] + hi_a[2] + hi_a[3], 0);

    // Basic duty on ch1.
    wr(1, 4);
    idle(48);
    clear_counts();
    idle(16);
    check_eq("basic_ch1_hi", hi_a[1], 4);
    check_eq("basic_ch0_hi", hi_a[0], 0);
    check_eq("basic_ch3_hi", hi_a[3], 0);

    // Extremes.
    wr(0, 0);
    wr(2, 15);
    idle(48);
    clear_counts();
    idle(16);
    check_eq("ext_ch0_hi", hi_a[0], 0);
    check_eq("ext_ch2_hi", hi_a[2], 15);
    check_eq("ext_ch1_hi", hi_a[1], 4);

    // Change ch1 4->8 mid-period at cnt=2.
    wait_cnt(0, 0);
    clear_counts();
    cycle(8'h18, 1'b1);
    cycle(8'h18, 1'b1);
    cycle(8'h98, 1'b1);
    for (int k = 0; k < 13; k++) cycle(8'h18, 1'b1);
    check_eq("glitch_cur_period", hi_a[1], 4);
    clear_counts();
    idle(16);
    check_eq("glitch_next_period", hi_a[1], 8);

    // Write landing on the wrap edge is deferred one period.
    wait_cnt(0, 15 - LAT);
    cycle(8'h92, 1'b1);
    wait_cnt(0, 0);
    clear_counts();
    idle(16);
    check_eq("wrap_write_deferred", hi_a[1], 8);
    clear_counts();
    idle(16);
    check_eq("wrap_write_applied", hi_a[1], 2);

    // Select 5 is out of range on the 4-channel instance.
    wr(5, 7);
    idle(48);
    clear_counts();
    idle(16);
    check_eq("sel5_ch0", hi_a[0], 0);
    check_eq("sel5_ch1", hi_a[1], 2);
    check_eq("sel5_ch2", hi_a[2], 15);
    check_eq("sel5_ch3", hi_a[3], 0);

    // 8-bit duty via two nibbles on ch7 of the 8x8 instance.
    wr(7, 4'hA);
    wr(7, 4'h5);
    idle(256);
    wait_cnt(1, 0);
    clear_counts();
    idle(256);
    check_eq("w8_ch7_hi", hi_b[7], 165);

    // Freeze 10 cycles mid-pulse: held high, period stretched to 266.
    wait_cnt(1, 0);
    clear_counts();
    idle(100);
    for (int k = 0; k < 10; k++) cycle(8'h00, 1'b0);
    idle(156);
    check_eq("freeze_ch7_hi", hi_b[7], 175);
    clear_counts();
    idle(256);
    check_eq("after_freeze_ch7_hi", hi_b[7], 165);

    // Write two edges before wrap: applied next period only without sync.
    wait_cnt(0, 14);
    cycle(8'h93, 1'b1);
    wait_cnt(0, 0);
    clear_counts();
    idle(16);
    check_eq("latency_next_period", hi_a[1], (LAT == 0) ? 3 : 2);
    clear_counts();
    idle(16);
    check_eq("latency_following", hi_a[1], 3);

    // Asynchronous reset at cnt=6 clears outputs immediately.
    wait_cnt(0, 6);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("async_rst_a", {24'd0, uo_a}, 32'h0);
    check_eq("async_rst_b", {24'd0, uo_b}, 32'h0);
    for (int k = 0; k < 3; k++) cycle(8'h00, 1'b1);
    rst_n = 1'b1;
    idle(48);
    clear_counts();
    idle(16);
    check_eq("post_rst_a_ch2", hi_a[2], 0);
    check_eq("post_rst_a_ch1", hi_a[1], 0);
    check_eq("post_rst_b_ch7", hi_b[7], 0);

    // Strobe high across reset release fires one write.
    rst_n = 1'b0;
    model_reset();
    cycle(8'h96, 1'b1);
    cycle(8'h96, 1'b1);
    rst_n = 1'b1;
    cycle(8'h96, 1'b1);
    cycle(8'h16, 1'b1);
    idle(48);
    clear_counts();
    idle(16);
    check_eq("rst_release_write", hi_a[1], 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
